// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two requesters; ALU_ARB_OPCHK_EN rejects opcodes 1xx with ERR.
// Latency: ACK at edge k, DONE at k+SETTLE_CYCLES; requests are held off (not acked) while BUSY.
module alu_arbiter #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic [2:0] OP0,
    input  logic [7:0] A0,
    input  logic [7:0] B0,
    output logic       ACK0,
    output logic       DONE0,
    input  logic       REQ1,
    input  logic [2:0] OP1,
    input  logic [7:0] A1,
    input  logic [7:0] B1,
    output logic       ACK1,
    output logic       DONE1,
    output logic [7:0] RES,
    output logic       ZF,
    output logic       ERR,
    output logic       BUSY,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic [2:0] ALU_SELECT,
    input  logic [7:0] ALU_RESULT,
    input  logic       ALU_ZERO
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_ERR} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             gnt, last;
    logic             grant_vld, grant_sel, capture, err_done;
    logic [2:0]       sel_op;
    logic [7:0]       sel_a, sel_b;
    logic             sel_bad;

    // Requester 1 wins when alone, or when both ask and requester 0 was served last.
    always_comb begin
        grant_sel = REQ1 & (~REQ0 | ~last);
        sel_op    = grant_sel ? OP1 : OP0;
        sel_a     = grant_sel ? A1  : A0;
        sel_b     = grant_sel ? B1  : B0;
    end

`ifdef ALU_ARB_OPCHK_EN
    assign sel_bad = sel_op[2];
`else
    assign sel_bad = 1'b0;
`endif

    assign BUSY = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        capture   = 1'b0;
        err_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    grant_vld = 1'b1;
                    if (sel_bad)
                        state_nxt = S_ERR;
                    else if (SETTLE_CYCLES == 1)
                        state_nxt = S_CAPT;
                    else
                        state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == CNT_W'(1))
                    state_nxt = S_CAPT;
            end
            S_CAPT: begin
                capture   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                err_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= S_IDLE;
            cnt        <= '0;
            gnt        <= 1'b0;
            last       <= 1'b1;
            ACK0       <= 1'b0;
            ACK1       <= 1'b0;
            DONE0      <= 1'b0;
            DONE1      <= 1'b0;
            RES        <= 8'h00;
            ZF         <= 1'b0;
            ALU_DATA1  <= 8'h00;
            ALU_DATA2  <= 8'h00;
            ALU_SELECT <= 3'b000;
        end else begin
            state <= state_nxt;
            ACK0  <= 1'b0;
            ACK1  <= 1'b0;
            DONE0 <= 1'b0;
            DONE1 <= 1'b0;
            if (grant_vld) begin
                gnt  <= grant_sel;
                last <= grant_sel;
                ACK0 <= ~grant_sel;
                ACK1 <= grant_sel;
                cnt  <= CNT_W'(SETTLE_CYCLES - 1);
                // A rejected opcode never reaches the ALU, so its inputs keep the previous op.
                if (!sel_bad) begin
                    ALU_DATA1  <= sel_a;
                    ALU_DATA2  <= sel_b;
                    ALU_SELECT <= sel_op;
                end
            end
            if (state == S_WAIT)
                cnt <= cnt - CNT_W'(1);
            if (capture) begin
                RES <= ALU_RESULT;
                ZF  <= ALU_ZERO;
            end
            if (capture || err_done) begin
                DONE0 <= ~gnt;
                DONE1 <= gnt;
            end
        end
    end

`ifdef ALU_ARB_OPCHK_EN
    always_ff @(posedge CLK) begin
        if (!RESET)
            ERR <= 1'b0;
        else if (capture)
            ERR <= 1'b0;
        else if (err_done)
            ERR <= 1'b1;
    end
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU (forward/add/and/or, SELECT 000–011) between two requesters, e.g. CPU execute stage and the cache/address-calculation unit.
- Registers operands and opcode, drives the ALU inputs, waits a fixed settle interval for the ALU's combinational delays, then captures RESULT/ZERO and returns them to the granted requester.
- Round-robin fairness; one operation in flight at a time.

Parameters:
- SETTLE_CYCLES, 1, cycles between driving ALU inputs and sampling ALU_RESULT/ALU_ZERO. Minimum 1.
- CNT_W, 3, width of the settle counter. Must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-low reset; sampled on the CLK rising edge.
- REQ0  in  1  requester 0 request.
- OP0  in  3  requester 0 ALU SELECT code.
- A0  in  8  requester 0 DATA1 operand.
- B0  in  8  requester 0 DATA2 operand.
- ACK0  out  1  one-cycle pulse: request 0 accepted, operands latched.
- DONE0  out  1  one-cycle pulse: result for requester 0 valid on RES/ZF.
- REQ1, OP1, A1, B1, ACK1, DONE1  as above, for requester 1.
- RES  out  8  captured ALU result; holds until the next capture.
- ZF  out  1  captured ALU zero flag; holds until the next capture.
- ERR  out  1  illegal-op flag; qualified by DONEx.
- BUSY  out  1  high in every state other than IDLE.
- ALU_DATA1  out  8  registered drive to the ALU DATA1 input.
- ALU_DATA2  out  8  registered drive to the ALU DATA2 input.
- ALU_SELECT  out  3  registered drive to the ALU SELECT input.
- ALU_RESULT  in  8  from the ALU RESULT output.
- ALU_ZERO  in  1  from the ALU ZERO output.

Behaviour:
- Reset (RESET=0 at an edge):
  - state=IDLE; ALU_DATA1=ALU_DATA2=0; ALU_SELECT=000.
  - RES=0, ZF=0, ERR=0; ACKx=DONEx=0; BUSY=0; LAST=1, so requester 0 wins the first contention.
- Reset mid-operation: the in-flight op is dropped, no DONE is issued, and the requester must re-request.
- Requester handshake:
  - Hold REQx high with OPx/Ax/Bx stable until ACKx is seen.
  - Operands may change from the cycle after ACKx.
  - The requester must not raise REQx again before its DONEx.
- FSM states: IDLE, WAIT, CAPT.
- IDLE, at an edge with any REQ high:
  - Pick the grantee. If only one requests, grant it. If both request, grant the one not equal to LAST.
  - Latch Ax→ALU_DATA1, Bx→ALU_DATA2, OPx→ALU_SELECT.
  - Set GNT=x, LAST=x, ACKx=1, cnt=SETTLE_CYCLES-1.
  - Go to CAPT if SETTLE_CYCLES=1, else to WAIT.
- IDLE with no request: outputs hold; pulses are 0.
- WAIT: decrement cnt each edge; go to CAPT when cnt reaches 1.
- CAPT, at the edge:
  - RES←ALU_RESULT, ZF←ALU_ZERO, DONE[GNT]=1, ERR=0.
  - Go to IDLE.
- Latency:
  - ACK on edge k.
  - DONE on edge k+SETTLE_CYCLES.
  - Next grant no earlier than edge k+SETTLE_CYCLES+1.
  - Throughput: one op per SETTLE_CYCLES+1 cycles.
- ALU_DATA1/2 and ALU_SELECT hold their last values while IDLE; they are not cleared between ops.
- A request arriving while BUSY is not acked; it is evaluated in IDLE.
- Requests present on the same edge as DONE are evaluated on the following edge.
- Arithmetic is the ALU's, modulo 2^8; subtraction is the requester's responsibility (negate B beforehand). The arbiter never alters operand values.

Optional Feature:
- Macro: ALU_ARB_OPCHK_EN.
- Defined:
  - In IDLE, an op with OPx[2]=1 (100–111) is acked normally, but ALU_* drives are not updated.
  - The FSM goes straight to an ERR state.
  - On the next edge: DONEx=1, ERR=1, RES/ZF unchanged; then IDLE.
- Not defined:
  - Illegal ops are forwarded like any other; the captured RES is whatever the ALU produces (X).
  - ERR is tied 0.

Test Plan:
- Single op: REQ0, OP0=001, A0=0x05, B0=0x03, SETTLE_CYCLES=1 → ACK0 at edge k, DONE0 at k+1, RES=0x08, ZF=0, BUSY high one cycle.
- Wrap/zero: OP=001, A=0xFF, B=0x01 → RES=0x00, ZF=1. Also A=0x05, B=0xFB → RES=0x00, ZF=1.
- Contention: REQ0 and REQ1 both high from reset.
  - Req0 op 010 (0xF0 & 0x3C) is served first → RES=0x30.
  - Req1 op 011 (0x0F | 0x30) is acked at DONE0 edge+1 → RES=0x3F.
  - Repeat contention → req1 served first (round-robin).
- Settle: SETTLE_CYCLES=3, OP=000, B=0xAA → DONE exactly 3 edges after ACK, RES=0xAA; RES holds 0xAA while idle.
- Reset mid-op: RESET=0 during WAIT → no DONE0 at any later edge; all outputs at reset values on the next edge; a fresh request then completes normally.
- With ALU_ARB_OPCHK_EN: OP0=101 → ACK0 then DONE0 next edge, ERR=1, RES unchanged from the prior op, ALU_SELECT unchanged.
